// File: rtl/conv_layer_mem.sv
// Five-bank result memory for the CONV engine: one-cycle CONV read/write port plus
// a valid/ready dump port that streams a whole bank out for host-side checking.
//
// state  | meaning
// D_IDLE | no dump in progress, waiting for dump_start
// D_RD   | reading the latched bank at dump_addr (stalls while CONV reads)
// D_OUT  | presenting the captured word, waiting for dout_ready
module conv_layer_mem #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int L0_DEPTH   = 4096,
  parameter int L1_DEPTH   = 1024,
  parameter int L2_DEPTH   = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cwr,
  input  logic [ADDR_WIDTH-1:0] caddr_wr,
  input  logic [DATA_WIDTH-1:0] cdata_wr,
  input  logic                  crd,
  input  logic [ADDR_WIDTH-1:0] caddr_rd,
  output logic [DATA_WIDTH-1:0] cdata_rd,
  input  logic [2:0]            csel,
  input  logic                  dump_start,
  input  logic [2:0]            dump_sel,
  output logic                  dump_busy,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic [ADDR_WIDTH-1:0] dout_addr,
  output logic                  dout_last,
  output logic                  err_addr,
  output logic                  err_sel
);

  localparam int L0_AW = $clog2(L0_DEPTH);
  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int L2_AW = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {D_IDLE, D_RD, D_OUT} dump_state_t;

  dump_state_t state, state_next;
  logic [2:0]            dump_bank;
  logic [ADDR_WIDTH-1:0] dump_addr;

  logic [DATA_WIDTH-1:0] mem_l0k0 [L0_DEPTH];
  logic [DATA_WIDTH-1:0] mem_l0k1 [L0_DEPTH];
  logic [DATA_WIDTH-1:0] mem_l1k0 [L1_DEPTH];
  logic [DATA_WIDTH-1:0] mem_l1k1 [L1_DEPTH];
  logic [DATA_WIDTH-1:0] mem_l2   [L2_DEPTH];

  // Zero depth doubles as the invalid-select marker.
  function automatic logic [31:0] depth_of(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: return 32'(L0_DEPTH);
      3'd3, 3'd4: return 32'(L1_DEPTH);
      3'd5:       return 32'(L2_DEPTH);
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic sel_ok(input logic [2:0] sel);
    return depth_of(sel) != 32'd0;
  endfunction

  function automatic logic in_range(input logic [2:0] sel, input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < depth_of(sel);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_bank(input logic [2:0] sel,
                                                      input logic [ADDR_WIDTH-1:0] a);
    case (sel)
      3'd1:    return mem_l0k0[a[L0_AW-1:0]];
      3'd2:    return mem_l0k1[a[L0_AW-1:0]];
      3'd3:    return mem_l1k0[a[L1_AW-1:0]];
      3'd4:    return mem_l1k1[a[L1_AW-1:0]];
      3'd5:    return mem_l2[a[L2_AW-1:0]];
      default: return '0;
    endcase
  endfunction

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (cwr && in_range(csel, caddr_wr)) begin
      case (csel)
        3'd1:    mem_l0k0[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd2:    mem_l0k1[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'd3:    mem_l1k0[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd4:    mem_l1k1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'd5:    mem_l2[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= D_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      D_IDLE:  if (dump_start && sel_ok(dump_sel)) state_next = D_RD;
      D_RD:    if (!crd) state_next = D_OUT;
      D_OUT:   if (dout_ready) state_next = dout_last ? D_IDLE : D_RD;
      default: state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdata_rd   <= '0;
      dump_busy  <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_addr  <= '0;
      dout_last  <= 1'b0;
      err_addr   <= 1'b0;
      err_sel    <= 1'b0;
      dump_bank  <= '0;
      dump_addr  <= '0;
    end else begin
      if (crd)
        cdata_rd <= in_range(csel, caddr_rd) ? read_bank(csel, caddr_rd) : '0;

      if ((cwr || crd) && !sel_ok(csel))
        err_sel <= 1'b1;
      if (state == D_IDLE && dump_start && !sel_ok(dump_sel))
        err_sel <= 1'b1;
      if ((cwr && sel_ok(csel) && !in_range(csel, caddr_wr)) ||
          (crd && sel_ok(csel) && !in_range(csel, caddr_rd)))
        err_addr <= 1'b1;

      case (state)
        D_IDLE: begin
          if (dump_start && sel_ok(dump_sel)) begin
            dump_bank <= dump_sel;
            dump_addr <= '0;
          end
        end
        // CONV owns the read port whenever crd is high.
        D_RD: begin
          if (!crd) begin
            dout_data <= read_bank(dump_bank, dump_addr);
            dout_addr <= dump_addr;
            dout_last <= 32'(dump_addr) == depth_of(dump_bank) - 32'd1;
          end
        end
        D_OUT: begin
          if (dout_ready && !dout_last)
            dump_addr <= dump_addr + ADDR_WIDTH'(1);
        end
        default: ;
      endcase

      dump_busy  <= state_next != D_IDLE;
      dout_valid <= state_next == D_OUT;
    end
  end

endmodule

// File: tb/tb_conv_layer_mem.sv
// Scoreboard bench for conv_layer_mem: directed CONV accesses and bank dumps, with
// expected words queued at issue time and checked by independent monitors.
module tb_conv_layer_mem;
  localparam int DW = 20;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cwr = 1'b0;
  logic [AW-1:0] caddr_wr = '0;
  logic [DW-1:0] cdata_wr = '0;
  logic          crd = 1'b0;
  logic [AW-1:0] caddr_rd = '0;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel = 3'd0;
  logic          dump_start = 1'b0;
  logic [2:0]    dump_sel = 3'd0;
  logic          dump_busy;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [DW-1:0] dout_data;
  logic [AW-1:0] dout_addr;
  logic          dout_last;
  logic          err_addr;
  logic          err_sel;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } dword_t;

  dword_t        dump_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] model [8][4096];
  dword_t        e;
  logic [DW-1:0] rexp;
  logic          rd_fire = 1'b0;
  int            dump_cnt = 0;
  int            ready_mode = 0;
  int            checks = 0;
  int            errors = 0;

  conv_layer_mem dut (
    .clk(clk), .reset(reset),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .dump_start(dump_start), .dump_sel(dump_sel), .dump_busy(dump_busy),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_addr(dout_addr), .dout_last(dout_last),
    .err_addr(err_addr), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int tb_depth(input logic [2:0] s);
    case (s)
      3'd1, 3'd2: return 4096;
      3'd3, 3'd4: return 1024;
      3'd5:       return 2048;
      default:    return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // CONV read monitor: a read issued at an edge is checked at the following negedge.
  always @(posedge clk) rd_fire <= crd && !reset;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL conv_read_unexpected actual=%h required=none", cdata_rd);
      end else begin
        rexp = rd_q.pop_front();
        chk("conv_read", 32'(cdata_rd), 32'(rexp));
      end
    end
    if (dout_valid && !reset) begin
      if (dump_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dump_unexpected actual=addr %h data %h required=none", dout_addr, dout_data);
      end else begin
        e = dump_q[0];
        chk("dump_addr", 32'(dout_addr), 32'(e.addr));
        chk("dump_data", 32'(dout_data), 32'(e.data));
        chk("dump_last", 32'(dout_last), 32'(e.last));
        if (dout_ready) begin
          void'(dump_q.pop_front());
          dump_cnt++;
        end
      end
    end
  end

  task automatic wr(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
    tick();
    cwr = 1'b0;
    if (int'(a) < tb_depth(s)) model[s][a] = d;
  endtask

  task automatic rd(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    crd = 1'b1; csel = s; caddr_rd = a;
    rd_q.push_back(exp);
    tick();
    crd = 1'b0;
  endtask

  task automatic start_dump(input logic [2:0] s, input int n);
    dword_t w;
    for (int i = 0; i < n; i++) begin
      w.addr = AW'(i);
      w.data = model[s][i];
      w.last = (i == tb_depth(s) - 1);
      dump_q.push_back(w);
    end
    dump_start = 1'b1; dump_sel = s;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic wait_dump_done(input string name, input int limit);
    int n;
    n = 0;
    while (dump_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (dump_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d words left required=0", name, dump_q.size());
      dump_q.delete();
    end
  endtask

  task automatic wait_count(input string name, input int target, input int limit);
    int n;
    n = 0;
    while (dump_cnt < target && n < limit) begin
      tick();
      n++;
    end
    if (dump_cnt < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, dump_cnt, target);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cdata_rd"},   32'(cdata_rd),   32'd0);
    chk({tag, "_dump_busy"},  32'(dump_busy),  32'd0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_dout_data"},  32'(dout_data),  32'd0);
    chk({tag, "_dout_addr"},  32'(dout_addr),  32'd0);
    chk({tag, "_dout_last"},  32'(dout_last),  32'd0);
    chk({tag, "_err_addr"},   32'(err_addr),   32'd0);
    chk({tag, "_err_sel"},    32'(err_sel),    32'd0);
  endtask

  initial begin
    int base;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Write/readback and bank independence
    wr(3'd1, 12'd5, 20'h0ABCD);
    wr(3'd2, 12'd5, 20'h12345);
    rd(3'd1, 12'd5, 20'h0ABCD);
    rd(3'd2, 12'd5, 20'h12345);
    rd(3'd1, 12'd5, 20'h0ABCD);

    // Same-cycle read and write to one address returns old data
    wr(3'd3, 12'd7, 20'h00011);
    cwr = 1'b1; crd = 1'b1; csel = 3'd3;
    caddr_wr = 12'd7; caddr_rd = 12'd7; cdata_wr = 20'h00022;
    rd_q.push_back(20'h00011);
    tick();
    cwr = 1'b0; crd = 1'b0;
    model[3][7] = 20'h00022;
    rd(3'd3, 12'd7, 20'h00022);
    chk("no_err_addr_yet", 32'(err_addr), 32'd0);
    chk("no_err_sel_yet",  32'(err_sel),  32'd0);

    // Range and select errors, sticky
    wr(3'd3, 12'd0, 20'h00F00);
    wr(3'd3, 12'd1024, 20'hBAD00);
    chk("err_addr_set", 32'(err_addr), 32'd1);
    chk("err_sel_clear", 32'(err_sel), 32'd0);
    rd(3'd3, 12'd0, 20'h00F00);
    rd(3'd6, 12'd3, 20'h00000);
    chk("err_sel_set", 32'(err_sel), 32'd1);
    wr(3'd1, 12'd6, 20'h00066);
    rd(3'd1, 12'd6, 20'h00066);
    chk("err_addr_sticky", 32'(err_addr), 32'd1);
    chk("err_sel_sticky",  32'(err_sel),  32'd1);
    dump_start = 1'b1; dump_sel = 3'd0;
    tick();
    dump_start = 1'b0;
    chk("bad_dump_not_busy", 32'(dump_busy), 32'd0);
    tick();
    chk("bad_dump_no_valid", 32'(dout_valid), 32'd0);

    // Fill banks for dumping
    for (int a = 0; a < 2048; a++) wr(3'd5, AW'(a), DW'(a));
    for (int a = 0; a < 1024; a++) wr(3'd4, AW'(a), DW'(a) ^ 20'hA5A5A);
    for (int a = 0; a < 400; a++)  wr(3'd1, AW'(a), DW'(a) | 20'h40000);

    // Full L2 dump under random backpressure
    ready_mode = 2;
    start_dump(3'd5, 2048);
    chk("l2_dump_busy", 32'(dump_busy), 32'd1);
    wait_dump_done("l2_dump", 20000);
    chk("l2_busy_after_last", 32'(dump_busy), 32'd0);
    chk("l2_valid_after_last", 32'(dout_valid), 32'd0);

    // CONV reads take priority over an L1K1 dump
    ready_mode = 1;
    start_dump(3'd4, 1024);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      crd = 1'b1; csel = 3'd4; caddr_rd = AW'(500 + i);
      rd_q.push_back(model[4][500 + i]);
      tick();
    end
    crd = 1'b0;
    chk("arb_busy", 32'(dump_busy), 32'd1);
    wait_dump_done("l1k1_dump", 5000);
    chk("arb_busy_after", 32'(dump_busy), 32'd0);

    // Reset after word 300 of an L0 dump, then restart from address 0
    base = dump_cnt;
    start_dump(3'd1, 300);
    wait_count("l0_dump", base + 300, 2000);
    reset = 1'b1;
    tick();
    check_zero("mid_dump_reset");
    reset = 1'b0;
    tick();
    chk("no_valid_after_reset", 32'(dout_valid), 32'd0);
    base = dump_cnt;
    start_dump(3'd1, 20);
    wait_count("l0_restart", base + 10, 200);
    reset = 1'b1;
    dump_q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_mem.md
Name: conv_layer_mem

Overview:
- Synthesizable layer-memory responder for the CONV engine's result interface (cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, csel).
- Stores the five result banks: L0 kernel0/1, L1 kernel0/1, L2 flatten. Services CONV writes and reads with fixed one-cycle read latency.
- Provides a host-side dump port that streams any bank out over a valid/ready handshake for result checking.

Parameters:
- DATA_WIDTH, 20, word width (signed 4.16 fixed-point, stored opaquely).
- ADDR_WIDTH, 12, caddr width.
- L0_DEPTH, 4096, words per L0 bank.
- L1_DEPTH, 1024, words per L1 bank.
- L2_DEPTH, 2048, words in L2 bank.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cwr  in  1  write strobe from CONV.
- caddr_wr  in  ADDR_WIDTH  write address.
- cdata_wr  in  DATA_WIDTH  write data.
- crd  in  1  read strobe from CONV.
- caddr_rd  in  ADDR_WIDTH  read address.
- cdata_rd  out  DATA_WIDTH  read data, registered.
- csel  in  3  bank select: 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2; 000/110/111 invalid.
- dump_start  in  1  one-cycle pulse that starts a bank dump.
- dump_sel  in  3  bank to dump, same encoding as csel; sampled with dump_start.
- dump_busy  out  1  high while a dump is in progress.
- dout_valid  out  1  dump word valid.
- dout_ready  in  1  host accepts the word.
- dout_data  out  DATA_WIDTH  dump word.
- dout_addr  out  ADDR_WIDTH  address of dout_data.
- dout_last  out  1  high with the final word of the bank.
- err_addr  out  1  sticky flag: access beyond bank depth.
- err_sel  out  1  sticky flag: access or dump with invalid select.

Behaviour:
- Reset
  - Registered outputs clear to 0: cdata_rd, dump_busy, dout_valid, dout_data, dout_addr, dout_last, err_addr, err_sel.
  - Dump FSM returns to D_IDLE.
  - Memory contents are not cleared.
  - Reset mid-dump aborts the dump with no further dout_valid.
- Write
  - If cwr=1, csel is valid and caddr_wr < depth(csel), mem[csel][caddr_wr] <= cdata_wr at the edge.
  - Invalid csel: write dropped, err_sel set.
  - Out-of-range address: write dropped, err_addr set.
- CONV read
  - If crd=1 at edge N, cdata_rd is valid after edge N and holds until the next CONV read.
  - Invalid csel or out-of-range address: cdata_rd <= 0 and the matching error flag is set.
- Read and write in the same cycle
  - Both use the same csel.
  - If the addresses match, cdata_rd returns the old data (read-before-write) and the write still commits.
- Error flags are sticky until reset.
- Dump FSM states:
  - D_IDLE: on dump_start with valid dump_sel, latch the bank, set addr=0, raise dump_busy, go to D_RD. Invalid dump_sel: set err_sel, stay in D_IDLE.
  - D_RD: issue an internal read of latched bank[addr]. If crd=1 this cycle, CONV has priority; hold in D_RD. Otherwise data is registered at the edge and the FSM goes to D_OUT.
  - D_OUT:
    - Drive dout_valid=1, dout_data, dout_addr=addr, dout_last=(addr==depth-1).
    - Hold all dout_* stable until dout_ready=1.
    - On handshake, if last: clear dout_valid and dump_busy, go to D_IDLE. Otherwise addr+1 and go to D_RD.
- dump_start is ignored while dump_busy=1.
- CONV writes during a dump are allowed. A word already captured is not updated; later addresses see the new data.
- Dump throughput: at best 1 word per 2 cycles.
- Address counter is ADDR_WIDTH wide, with no wrap beyond depth-1.

Test Plan:
- Write/readback: csel=001, write 20'h0ABCD at addr 5, then crd addr 5 → cdata_rd=20'h0ABCD one cycle after crd; also verify csel=010 addr 5 is independent of csel=001 addr 5.
- Same-cycle RAW: mem L1K0[7]=20'h00011; in one cycle cwr=1/crd=1 at addr 7 with data 20'h00022 → cdata_rd=20'h00011; next read of addr 7 → 20'h00022.
- Range/select errors: csel=011 write addr 1024 → no write, err_addr=1; csel=110 crd → cdata_rd=0, err_sel=1; both flags stay set until reset.
- Full dump with backpressure: fill L2 with addr-valued data, dump_sel=101, dout_ready toggled randomly → 2048 words in order, with data equal to addr and stable while stalled; dout_last only at addr 2047; dump_busy falls after the last handshake.
- Arbitration: during an L1K1 dump, hold crd=1 for 10 cycles → CONV reads correct every cycle, dump stalls without skipping or duplicating addresses.
- Reset mid-dump: synchronous reset at word 300 of an L0 dump → all outputs 0 next cycle; a new dump_start then begins from addr 0.
